// File: rtl/edge_scan_ctrl.sv
// Scan sequencer for the edge-detection datapath: row-major then column-major
// raster with frame-buffer address. Optional blank-frame timeout: EDGE_SCAN_TIMEOUT_EN.
module edge_scan_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 19,
    parameter int MAX_PASSES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              iStart,
    input  logic [1:0]        iFinish,
    output logic [9:0]        oRow,
    output logic [9:0]        oCol,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oHscan,
    output logic              oVscan,
    output logic              oClear,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr
);

    if ((64'(1) << ADDR_W) < 64'(H_ACTIVE) * 64'(V_ACTIVE)) begin : g_bad_addr_w
        $error("ADDR_W too small for H_ACTIVE*V_ACTIVE");
    end
    if (MAX_PASSES < 1) begin : g_bad_max_passes
        $error("MAX_PASSES must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, CLEAR, HSCAN, VSCAN, DONE} state_t;

    state_t     state_q, state_d;
    logic [9:0] row_q, row_d, col_q, col_d;
    logic       hscan_q, hscan_d, vscan_q, vscan_d;
    logic       clear_q, clear_d, busy_q, busy_d, done_q, done_d;
    logic       last_col, last_row, frame_wrap;

    assign last_col = (col_q == 10'(H_ACTIVE - 1));
    assign last_row = (row_q == 10'(V_ACTIVE - 1));

`ifdef EDGE_SCAN_TIMEOUT_EN
    localparam int PASS_W = $clog2(MAX_PASSES + 1);
    logic [PASS_W-1:0] pass_q, pass_d;
    logic              err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        frame_wrap = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (iStart) begin
                    state_d = CLEAR;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            CLEAR: begin
                state_d = HSCAN;
                row_d   = '0;
                col_d   = '0;
            end
            HSCAN: begin
                // bounds-found wins over stepping, even when paused
                if (iFinish[0]) begin
                    state_d = VSCAN;
                    row_d   = '0;
                    col_d   = '0;
                end else if (en) begin
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            row_d      = '0;
                            frame_wrap = 1'b1;
                        end else begin
                            row_d = row_q + 10'd1;
                        end
                    end else begin
                        col_d = col_q + 10'd1;
                    end
                end
            end
            VSCAN: begin
                if (iFinish[1]) begin
                    state_d = DONE;
                end else if (en) begin
                    if (last_row) begin
                        row_d = '0;
                        if (last_col) begin
                            col_d      = '0;
                            frame_wrap = 1'b1;
                        end else begin
                            col_d = col_q + 10'd1;
                        end
                    end else begin
                        row_d = row_q + 10'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef EDGE_SCAN_TIMEOUT_EN
        pass_d = pass_q;
        err_d  = err_q;
        if (state_d == CLEAR) begin
            err_d  = 1'b0;
            pass_d = '0;
        end else if (state_q == HSCAN && state_d == VSCAN) begin
            pass_d = '0;
        end else if (frame_wrap) begin
            pass_d = pass_q + 1'b1;
            if (pass_d == PASS_W'(MAX_PASSES)) begin
                state_d = DONE;
                err_d   = 1'b1;
            end
        end
`endif

        // outputs are registered, so they are decoded from the next state
        clear_d = (state_d == CLEAR);
        busy_d  = (state_d == CLEAR) || (state_d == HSCAN) || (state_d == VSCAN);
        done_d  = (state_d == DONE);
        hscan_d = (state_d == HSCAN) && en;
        vscan_d = (state_d == VSCAN) && en;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            hscan_q <= 1'b0;
            vscan_q <= 1'b0;
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef EDGE_SCAN_TIMEOUT_EN
            pass_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            hscan_q <= hscan_d;
            vscan_q <= vscan_d;
            clear_q <= clear_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef EDGE_SCAN_TIMEOUT_EN
            pass_q  <= pass_d;
            err_q   <= err_d;
`endif
        end
    end

    assign oRow   = row_q;
    assign oCol   = col_q;
    assign oAddr  = ADDR_W'(row_q) * ADDR_W'(H_ACTIVE) + ADDR_W'(col_q);
    assign oHscan = hscan_q;
    assign oVscan = vscan_q;
    assign oClear = clear_q;
    assign oBusy  = busy_q;
    assign oDone  = done_q;
`ifdef EDGE_SCAN_TIMEOUT_EN
    assign oErr   = err_q;
`else
    assign oErr   = 1'b0;
`endif

endmodule

// File: tb/tb_edge_scan_ctrl.sv
// Vector-table bench for edge_scan_ctrl on an 8x4 frame; expectations are
// queued when a vector is driven and compared after the following clock edge.
module tb_edge_scan_ctrl;
    localparam int HA = 8;
    localparam int VA = 4;
    localparam int AW = 19;
    localparam int MP = 2;
    localparam int FRAME = HA * VA;

    typedef struct packed {
        logic [9:0]    row;
        logic [9:0]    col;
        logic [AW-1:0] addr;
        logic hs, vs, clr, busy, done, err;
    } out_t;

    typedef struct {
        logic       en;
        logic       st;
        logic [1:0] fin;
        out_t       exp;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0, en = 1'b0, iStart = 1'b0;
    logic [1:0] iFinish = 2'b00;
    logic [9:0] oRow, oCol;
    logic [AW-1:0] oAddr;
    logic oHscan, oVscan, oClear, oBusy, oDone, oErr;

    int checks = 0, failures = 0;
    out_t exp_q[$];
    vec_t vecs[$];

    edge_scan_ctrl #(.H_ACTIVE(HA), .V_ACTIVE(VA), .ADDR_W(AW), .MAX_PASSES(MP)) dut (
        .clk(clk), .rst(rst), .en(en), .iStart(iStart), .iFinish(iFinish),
        .oRow(oRow), .oCol(oCol), .oAddr(oAddr), .oHscan(oHscan), .oVscan(oVscan),
        .oClear(oClear), .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic out_t mk(int r, int c, logic hs, logic vs, logic clr,
                                logic busy, logic done, logic err);
        out_t o;
        o.row = 10'(r); o.col = 10'(c); o.addr = AW'(r * HA + c);
        o.hs = hs; o.vs = vs; o.clr = clr; o.busy = busy; o.done = done; o.err = err;
        return o;
    endfunction

    function automatic out_t hpos(int k);
        int p = k % FRAME;
        return mk(p / HA, p % HA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic out_t vpos(int q);
        int p = q % FRAME;
        return mk(p % VA, p / VA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic out_t act();
        out_t o;
        o.row = oRow; o.col = oCol; o.addr = oAddr;
        o.hs = oHscan; o.vs = oVscan; o.clr = oClear; o.busy = oBusy; o.done = oDone; o.err = oErr;
        return o;
    endfunction

    function automatic void add(logic e, logic s, logic [1:0] f, out_t x);
        vec_t v;
        v.en = e; v.st = s; v.fin = f; v.exp = x;
        vecs.push_back(v);
    endfunction

    task automatic cmp(string name, out_t a, out_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got r=%0d c=%0d a=%0d hs=%b vs=%b clr=%b busy=%b done=%b err=%b, expected r=%0d c=%0d a=%0d hs=%b vs=%b clr=%b busy=%b done=%b err=%b",
                     name, a.row, a.col, a.addr, a.hs, a.vs, a.clr, a.busy, a.done, a.err,
                     e.row, e.col, e.addr, e.hs, e.vs, e.clr, e.busy, e.done, e.err);
        end
    endtask

    task automatic step(string name, logic e, logic s, logic [1:0] f, out_t x);
        en = e; iStart = s; iFinish = f;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        cmp(name, act(), exp_q.pop_front());
    endtask

    initial begin
        out_t zero, clr, done36;
        zero   = mk(0, 0, 0, 0, 0, 0, 0, 0);
        clr    = mk(0, 0, 0, 0, 1, 1, 0, 0);
        done36 = mk(3, 6, 0, 0, 0, 0, 1, 0);

        // idle, clear, then row-major scan; iFinish[1] alone is ignored in HSCAN
        add(1, 0, 2'b00, zero);
        add(1, 1, 2'b00, clr);
        add(1, 0, 2'b00, hpos(0));
        for (int k = 1; k <= 11; k++) add(1, 0, (k == 3 || k == 4) ? 2'b10 : 2'b00, hpos(k));
        // pause at (1,3); a start request while busy is ignored
        for (int i = 0; i < 5; i++) add(0, (i == 2), 2'b00, mk(1, 3, 0, 0, 0, 1, 0, 0));
        for (int k = 12; k <= 21; k++) add(1, 0, 2'b00, hpos(k));
        // row bounds at (2,5) -> column-major scan up to (3,6)
        add(1, 0, 2'b01, vpos(0));
        for (int q = 1; q <= 27; q++) add(1, 0, 2'b00, vpos(q));
        add(1, 0, 2'b11, done36);
        add(1, 0, 2'b01, done36);
        add(0, 0, 2'b10, done36);
        add(1, 1, 2'b00, clr);
        add(1, 0, 2'b00, hpos(0));
        add(1, 0, 2'b00, hpos(1));
        add(1, 0, 2'b00, hpos(2));
        // finish bits honoured while paused
        add(0, 0, 2'b01, mk(0, 0, 0, 0, 0, 1, 0, 0));
        add(0, 0, 2'b10, mk(0, 0, 0, 0, 0, 0, 1, 0));
        // blank frame: never any bounds
        add(1, 1, 2'b00, clr);
        add(1, 0, 2'b00, hpos(0));
        for (int k = 1; k <= 2 * FRAME; k++) begin
`ifdef EDGE_SCAN_TIMEOUT_EN
            add(1, 0, 2'b00, (k == MP * FRAME) ? mk(0, 0, 0, 0, 0, 0, 1, 1) : hpos(k));
`else
            add(1, 0, 2'b00, hpos(k));
`endif
        end
`ifdef EDGE_SCAN_TIMEOUT_EN
        add(1, 1, 2'b00, clr);
`endif

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_state", act(), zero);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("vec%0d", i), vecs[i].en, vecs[i].st, vecs[i].fin, vecs[i].exp);

        // reset mid-VSCAN at (2,4)
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step("rst_start", 1, 1, 2'b00, clr);
        step("rst_hscan", 1, 0, 2'b00, hpos(0));
        step("rst_vscan0", 1, 0, 2'b01, vpos(0));
        for (int q = 1; q <= 18; q++) step($sformatf("rst_v%0d", q), 1, 0, 2'b00, vpos(q));
        #2;
        rst = 1'b0;
        iStart = 1'b1;
        #1;
        cmp("async_reset", act(), zero);
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_ignores_start", act(), zero);
        rst = 1'b1;
        step("idle_after_reset", 1, 0, 2'b00, zero);
        step("start_after_reset", 1, 1, 2'b00, clr);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/edge_scan_ctrl.md
Name: edge_scan_ctrl

Overview:
Sequencer for the edge_detection datapath in the digit-recognition pipeline. It generates the row-major scan (top/bottom bounds), then the column-major scan (left/right bounds), and the matching frame-buffer address. It steps phases on the detector's ofinish bits and reports done/error to the downstream recognition stage. It replaces the ad-hoc address logic previously kept in simulation benches with a synthesizable FSM.

Parameters:
H_ACTIVE, 640, pixels per row; col wraps at H_ACTIVE-1
V_ACTIVE, 480, rows per frame; row wraps at V_ACTIVE-1
ADDR_W, 19, address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
MAX_PASSES, 2, full-frame wraps allowed per phase before timeout (used only with EDGE_SCAN_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
en  in  1  1 = scan advances; 0 = pause (counters hold)
iStart  in  1  start request, sampled in IDLE and DONE only
iFinish  in  2  detector ofinish; [0] = row bounds found, [1] = column bounds found
oRow  out  10  current row
oCol  out  10  current column
oAddr  out  ADDR_W  oRow*H_ACTIVE+oCol, combinational from oRow/oCol
oHscan  out  1  row-scan strobe to detector
oVscan  out  1  column-scan strobe to detector
oClear  out  1  one-cycle detector clear pulse
oBusy  out  1  high in CLEAR, HSCAN, VSCAN
oDone  out  1  level, high in DONE
oErr  out  1  timeout flag, valid while oDone=1

Behaviour:
- Reset (rst=0, async): state IDLE; oRow=oCol=0; oHscan=oVscan=oClear=oBusy=oDone=oErr=0; pass counter=0.
- All outputs except oAddr are registered. oAddr has zero latency relative to oRow/oCol.
- States: IDLE, CLEAR, HSCAN, VSCAN, DONE.
- IDLE: if iStart=1, go to CLEAR. Otherwise hold.
- CLEAR: exactly one cycle. oClear=1, row=col=0, oBusy=1. Next state is HSCAN unconditionally; en is ignored.
- HSCAN: oHscan = en.
  - Each cycle with en=1: col+1.
  - At col=H_ACTIVE-1: col=0 and row+1.
  - At (V_ACTIVE-1, H_ACTIVE-1): wrap to (0,0) and pass counter+1.
  - If iFinish[0]=1 (checked before increment, regardless of en): go to VSCAN, row=col=0, pass counter=0, oHscan=0. No increment that cycle.
  - iFinish[1] is ignored in HSCAN. If both bits are set, go to VSCAN only.
- VSCAN: oVscan = en.
  - Each cycle with en=1: row+1.
  - At row=V_ACTIVE-1: row=0 and col+1.
  - At (V_ACTIVE-1, H_ACTIVE-1): wrap to (0,0) and pass counter+1.
  - If iFinish[1]=1: go to DONE, oVscan=0; row/col hold their last value.
- DONE: oDone=1, oBusy=0.
  - iStart=1 goes to CLEAR, clearing oDone and oErr on entry.
  - iFinish changes are ignored.
- en=0 in HSCAN/VSCAN: row, col and pass counter hold; strobes are low; iFinish is still honoured.
- iStart while busy: ignored.
- Reset mid-scan: immediate return to the reset values above. No pulse on oClear.
- The counter compare uses equality with the parameter minus 1. Values above the limit never occur.

Optional Feature:
EDGE_SCAN_TIMEOUT_EN
- Defined: when the pass counter reaches MAX_PASSES in HSCAN or VSCAN, go to DONE with oErr=1 and strobes low. This covers a blank frame where no bounds are ever found.
- Not defined: no pass counter logic; scanning wraps indefinitely; oErr is tied to 0.

Test Plan:
1. H_ACTIVE=8, V_ACTIVE=4; reset, then pulse iStart.
   - Expect oClear=1 for 1 cycle.
   - Then oHscan=1 with (row,col) stepping 0,0 → 0,1 … 0,7 → 1,0.
   - oAddr at (1,0) = 8.
2. In HSCAN at (2,5), set iFinish=01.
   - Next cycle: VSCAN, (0,0), oVscan=1.
   - Then (1,0), (2,0), (3,0), (0,1); oAddr at (0,1) = 1.
3. In VSCAN at (3,6), set iFinish=11.
   - Next cycle: oDone=1, oBusy=0, strobes=0, (3,6) held.
   - A second iStart restarts via CLEAR.
4. Drive en=0 for 5 cycles mid-HSCAN at (1,3).
   - oHscan=0 and position stays (1,3).
   - Raise en: next position is (1,4).
5. With EDGE_SCAN_TIMEOUT_EN, MAX_PASSES=2, iFinish held at 00.
   - After 2*32 = 64 HSCAN cycles: oDone=1, oErr=1.
   - Without the macro: still HSCAN at cycle 64, oErr=0.
6. Assert rst=0 mid-VSCAN at (2,4): all outputs 0 asynchronously; iStart is ignored until rst=1.
